// File: rtl/isa_pkg.sv
`default_nettype none
// ============================================================================
// Module : isa_pkg
// Brief  : Shared ISA field layout, opcode and fetch/decode FSM encodings.
// Rev    : 1.0  initial release
// ============================================================================
package isa_pkg;

    localparam int OPC_W    = 4;
    localparam int REG_W    = 2;
    localparam int OPND_W   = 10;
    localparam int OPC_LSB  = 12;
    localparam int REG_LSB  = 10;
    localparam int OPND_LSB = 0;

    typedef enum logic [OPC_W-1:0] {
        OP_ADD   = 4'h0,
        OP_SUB   = 4'h1,
        OP_AND   = 4'h2,
        OP_OR    = 4'h3,
        OP_XOR   = 4'h4,
        OP_NOT   = 4'h5,
        OP_LOAD  = 4'h6,
        OP_STORE = 4'h7,
        OP_NOP   = 4'hF
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_ISSUE = 2'd2,
        ST_HALT  = 2'd3
    } state_e;

    // Upper half of the opcode space is reserved, apart from the NOP encoding.
    function automatic logic op_is_reserved(input logic [OPC_W-1:0] op);
        return op[OPC_W-1] && (op != OP_NOP);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_decode_unit_if.sv
`default_nettype none
// ============================================================================
// Module : fetch_decode_unit_if
// Brief  : Program-memory fetch port and decoded-instruction valid/ready port.
// Rev    : 1.0  initial release
// ============================================================================
interface fetch_decode_unit_if
    import isa_pkg::*;
#(
    parameter int ADDR_W  = 5,
    parameter int INSTR_W = 16
);
    logic [ADDR_W-1:0]  instruction_address;
    logic [INSTR_W-1:0] instruction;
    logic               dec_valid;
    logic               dec_ready;
    logic [OPC_W-1:0]   dec_opcode;
    logic [REG_W-1:0]   dec_reg;
    logic [OPND_W-1:0]  dec_operand;
    logic [ADDR_W-1:0]  dec_pc;

    modport master (
        output instruction_address,
        input  instruction,
        output dec_valid,
        input  dec_ready,
        output dec_opcode,
        output dec_reg,
        output dec_operand,
        output dec_pc
    );

    modport slave (
        input  instruction_address,
        output instruction,
        input  dec_valid,
        output dec_ready,
        input  dec_opcode,
        input  dec_reg,
        input  dec_operand,
        input  dec_pc
    );
endinterface
`default_nettype wire

// File: rtl/instr_decoder.sv
`default_nettype none
// ============================================================================
// Module : instr_decoder
// Brief  : Combinational split of an instruction word into fields and class.
// Rev    : 1.0  initial release
// ============================================================================
module instr_decoder
    import isa_pkg::*;
#(
    parameter int INSTR_W = 16
) (
    input  logic [INSTR_W-1:0] word_i,
    output logic [OPC_W-1:0]   opcode_o,
    output logic [REG_W-1:0]   reg_o,
    output logic [OPND_W-1:0]  operand_o,
    output logic               is_nop_o,
    output logic               is_illegal_o
);
    assign opcode_o     = word_i[OPC_LSB +: OPC_W];
    assign reg_o        = word_i[REG_LSB +: REG_W];
    assign operand_o    = word_i[OPND_LSB +: OPND_W];
    assign is_nop_o     = (opcode_o == OP_NOP);
    assign is_illegal_o = op_is_reserved(opcode_o);
endmodule
`default_nettype wire

// File: rtl/fetch_decode_unit.sv
`default_nettype none
// ============================================================================
// Module : fetch_decode_unit
// Brief  : Sequential fetch / decode / issue FSM with valid-ready output.
//          FETCH_ILLEGAL_TRAP_EN: reserved opcodes trap to HALT (else skipped).
// Rev    : 1.0  initial release
// ============================================================================
module fetch_decode_unit
    import isa_pkg::*;
#(
    parameter int ADDR_W  = 5,
    parameter int INSTR_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    fetch_decode_unit_if.master bus,
    output logic                busy,
    output logic                halted,
    output logic                illegal
);

`ifdef FETCH_ILLEGAL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    localparam logic [ADDR_W-1:0] PC_LAST = {ADDR_W{1'b1}};

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               illegal_q, illegal_d;

    logic [INSTR_W-1:0] w_dec_word;
    logic [OPC_W-1:0]   w_opcode;
    logic [REG_W-1:0]   w_reg;
    logic [OPND_W-1:0]  w_operand;
    logic               w_is_nop;
    logic               w_is_illegal;

    // Classify the live memory word while fetching; otherwise present the held copy.
    assign w_dec_word = (state_q == ST_FETCH) ? bus.instruction : instr_q;

    instr_decoder #(
        .INSTR_W (INSTR_W)
    ) u_instr_decoder (
        .word_i       (w_dec_word),
        .opcode_o     (w_opcode),
        .reg_o        (w_reg),
        .operand_o    (w_operand),
        .is_nop_o     (w_is_nop),
        .is_illegal_o (w_is_illegal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pc_q      <= '0;
            instr_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        illegal_d = illegal_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FETCH;
                    pc_d    = '0;
                end
            end
            ST_FETCH: begin
                instr_d = bus.instruction;
                if (w_is_illegal && TRAP_EN) begin
                    state_d   = ST_HALT;
                    illegal_d = 1'b1;
                end else if (w_is_nop || w_is_illegal) begin
                    // Skipped words cost one cycle each; the program space never wraps.
                    if (pc_q == PC_LAST) state_d = ST_HALT;
                    else                 pc_d    = pc_q + ADDR_W'(1);
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (bus.dec_ready) begin
                    if (pc_q == PC_LAST) begin
                        state_d = ST_HALT;
                    end else begin
                        state_d = ST_FETCH;
                        pc_d    = pc_q + ADDR_W'(1);
                    end
                end
            end
            ST_HALT: begin
                if (start) begin
                    state_d   = ST_FETCH;
                    pc_d      = '0;
                    illegal_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.instruction_address = pc_q;
    assign bus.dec_valid           = (state_q == ST_ISSUE);
    assign bus.dec_opcode          = w_opcode;
    assign bus.dec_reg             = w_reg;
    assign bus.dec_operand         = w_operand;
    assign bus.dec_pc              = pc_q;
    assign busy                    = (state_q == ST_FETCH) || (state_q == ST_ISSUE);
    assign halted                  = (state_q == ST_HALT);
    assign illegal                 = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_decode_unit.sv
`default_nettype none
// Randomized bench for fetch_decode_unit: an expected issue list is built by walking
// the program memory, then the DUT is driven with random back-pressure and checked.
module tb_fetch_decode_unit;

`ifdef FETCH_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif
    localparam int BUDGET = 40;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic busy, halted, illegal;
    logic [15:0] mem [32];

    fetch_decode_unit_if #(.ADDR_W(5), .INSTR_W(16)) bus ();

    assign bus.instruction = mem[bus.instruction_address];

    fetch_decode_unit #(.ADDR_W(5), .INSTR_W(16)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .bus     (bus),
        .busy    (busy),
        .halted  (halted),
        .illegal (illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          pc;
        logic [15:0] word;
        int          fetches;
    } issue_t;

    issue_t exp_q[$];
    int     end_f, end_pc;
    bit     end_ill;
    int     n_checks = 0;
    int     n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // Walk the program: every word costs one fetch cycle; legal words are issued,
    // NOP/reserved words are skipped, a trapped reserved word or the end of memory halts.
    function automatic void build_model();
        int f;
        logic [3:0] op;
        f = 0;
        end_ill = 1'b0;
        end_pc = 31;
        exp_q.delete();
        for (int p = 0; p < 32; p++) begin
            f++;
            op = mem[p][15:12];
            if (op <= 4'd7) begin
                exp_q.push_back('{pc: p, word: mem[p], fetches: f});
                f = 0;
            end else if (op != 4'hF && TRAP) begin
                end_ill = 1'b1;
                end_pc = p;
                break;
            end
        end
        end_f = f;
    endfunction

    function automatic logic [15:0] rand_word();
        int r;
        logic [3:0] op;
        r = $urandom_range(0, 9);
        if (r < 5)      op = 4'($urandom_range(0, 7));
        else if (r < 8) op = 4'hF;
        else            op = 4'($urandom_range(8, 14));
        return {op, 12'($urandom)};
    endfunction

    task automatic check_reset_state(input string tag);
        chk({tag, "_valid"},   32'(bus.dec_valid), 0);
        chk({tag, "_busy"},    32'(busy), 0);
        chk({tag, "_halted"},  32'(halted), 0);
        chk({tag, "_illegal"}, 32'(illegal), 0);
        chk({tag, "_addr"},    32'(bus.instruction_address), 0);
        chk({tag, "_fields"},  {bus.dec_opcode, bus.dec_reg, bus.dec_operand, bus.dec_pc}, 0);
    endtask

    task automatic check_issue(input issue_t e);
        chk("dec_valid",   32'(bus.dec_valid), 1);
        chk("dec_pc",      32'(bus.dec_pc), 32'(e.pc));
        chk("dec_opcode",  32'(bus.dec_opcode), 32'(e.word[15:12]));
        chk("dec_reg",     32'(bus.dec_reg), 32'(e.word[11:10]));
        chk("dec_operand", 32'(bus.dec_operand), 32'(e.word[9:0]));
    endtask

    // Called on the first negedge after a trigger edge; the awaited event must be
    // visible on negedge number (fetch cycles + 1).
    task automatic wait_event(input int f, input bit want_halt, output bit ok);
        int n;
        n = 1;
        while (!(want_halt ? halted : bus.dec_valid) && n < BUDGET) begin
            bus.dec_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            n++;
        end
        ok = (n < BUDGET);
        chk(want_halt ? "halt_latency" : "issue_latency", 32'(n), 32'(f + 1));
    endtask

    task automatic run_program(input int rst_pc);
        bit ok;
        int stalls;
        issue_t e;
        build_model();
        @(negedge clk);
        bus.dec_ready = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_busy", 32'(busy), 1);
        chk("start_illegal_clr", 32'(illegal), 0);
        foreach (exp_q[i]) begin
            e = exp_q[i];
            wait_event(e.fetches, 1'b0, ok);
            if (!ok) return;
            check_issue(e);
            if (e.pc == rst_pc) begin
                #2 rst_n = 1'b0;
                #1 check_reset_state("midreset");
                @(negedge clk);
                rst_n = 1'b1;
                repeat (3) begin
                    @(negedge clk);
                    chk("post_reset_idle_busy",  32'(busy), 0);
                    chk("post_reset_idle_valid", 32'(bus.dec_valid), 0);
                end
                return;
            end
            stalls = (e.pc == 1) ? 4 : $urandom_range(0, 4);
            repeat (stalls) begin
                bus.dec_ready = 1'b0;
                start = 1'($urandom_range(0, 1));
                @(negedge clk);
                check_issue(e);
            end
            start = 1'b0;
            bus.dec_ready = 1'b1;
            @(negedge clk);
        end
        wait_event(end_f, 1'b1, ok);
        if (!ok) return;
        chk("end_busy",    32'(busy), 0);
        chk("end_illegal", 32'(illegal), 32'(end_ill));
        chk("end_pc",      32'(bus.instruction_address), 32'(end_pc));
        repeat (2) begin
            bus.dec_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("halt_valid",  32'(bus.dec_valid), 0);
            chk("halt_stays",  32'(halted), 1);
        end
    endtask

    initial begin
        bus.dec_ready = 1'b0;
        for (int i = 0; i < 32; i++) mem[i] = 16'hF000;
        #1 check_reset_state("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_state("idle");

        // ADD r0 at 0, LOAD r1 #5 at 1 (held 4 cycles), reserved word at 3, XOR at 31
        for (int i = 0; i < 32; i++) mem[i] = rand_word();
        mem[0]  = 16'h0000;
        mem[1]  = 16'h6405;
        mem[2]  = 16'h2ABC;
        mem[3]  = 16'hA123;
        mem[4]  = 16'h1C0F;
        mem[31] = 16'h4155;
        run_program(-1);

        // Two leading NOPs, STORE r2, then NOPs to an XOR at 31 (restart from HALT)
        for (int i = 0; i < 32; i++) mem[i] = 16'hF000;
        mem[1]  = 16'hFFFF;
        mem[2]  = 16'h7800 | 16'($urandom_range(0, 1023));
        mem[31] = 16'h4C01;
        run_program(-1);

        // NOP at the last address halts directly
        mem[31] = 16'hF123;
        run_program(-1);

        // Reset while issuing the instruction at pc 7, then a clean run of the same program
        for (int i = 0; i < 32; i++) mem[i] = rand_word();
        for (int i = 0; i < 8; i++) mem[i] = {4'($urandom_range(0, 7)), 12'($urandom)};
        run_program(7);
        run_program(-1);

        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < 32; i++) mem[i] = rand_word();
            run_program(-1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_decode_unit.md
FETCH_DECODE_UNIT -- requirements
Module: fetch_decode_unit

Interface
REQ-001 Parameter ADDR_W, default 5, instruction address width (32-entry program space).
REQ-002 Parameter INSTR_W, default 16, instruction word width.
REQ-003 Clocking: one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  one-cycle pulse, begin execution from address 0.
REQ-007 instruction_address  output  ADDR_W  address to program memory.
REQ-008 instruction  input  INSTR_W  word from program memory, combinational on instruction_address.
REQ-009 dec_valid  output  1  decoded instruction available.
REQ-010 dec_ready  input  1  consumer accepts decoded instruction.
REQ-011 dec_opcode  output  4  instruction[15:12].
REQ-012 dec_reg  output  2  instruction[11:10].
REQ-013 dec_operand  output  10  instruction[9:0].
REQ-014 dec_pc  output  ADDR_W  address the issued instruction was fetched from.
REQ-015 busy  output  1  high in FETCH or ISSUE.
REQ-016 halted  output  1  high in HALT.
REQ-017 illegal  output  1  sticky illegal-opcode flag.

Function
REQ-018 FSM states IDLE, FETCH, ISSUE, HALT; IDLE->FETCH on start with pc=0.
REQ-019 FETCH: instruction_address=pc; instruction registered at end of cycle; fields decoded from registered copy.
REQ-020 Legal issuable opcodes: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 NOT, 0110 LOAD, 0111 STORE.
REQ-021 FETCH of legal opcode -> ISSUE next cycle; fetch-to-dec_valid latency exactly 1 cycle.
REQ-022 Opcode 1111 (NOP) never issued: pc increments, stays in FETCH (1 cycle per NOP).
REQ-023 ISSUE: dec_valid=1; dec_opcode/dec_reg/dec_operand/dec_pc stable until dec_valid&&dec_ready.
REQ-024 Handshake in ISSUE: pc<31 -> pc+1, FETCH; pc==31 -> HALT; no pc wrap-around.
REQ-025 NOP at pc==31 -> HALT directly.
REQ-026 dec_ready while dec_valid low has no effect; dec_valid never drops without handshake except on reset.
REQ-027 start in FETCH or ISSUE ignored; start in HALT restarts from pc=0 and clears illegal.
REQ-028 instruction_address equals pc in all states; outside FETCH, value is don't-care to memory.
REQ-029 Max throughput one instruction per 2 cycles.

Reset
REQ-030 On rst_n low, immediately: state IDLE, pc=0, instruction_address=0, dec_valid=0, dec_* fields=0, busy=0, halted=0, illegal=0.
REQ-031 Reset mid-ISSUE drops dec_valid asynchronously; no handshake completes in that cycle.

Configuration
REQ-032 Macro FETCH_ILLEGAL_TRAP_EN defined: opcodes 1000-1110 set illegal=1, not issued, FSM -> HALT next cycle, pc held at offending address.
REQ-033 Macro undefined: opcodes 1000-1110 handled exactly as NOP; illegal tied 0.

Structure
REQ-034 Shared package isa_pkg: opcode enum (all values above), field width/position constants, FSM state enum.
REQ-035 One combinational sub-module instr_decoder: word -> opcode/reg/operand fields plus is_nop/is_illegal.

Verification
REQ-036 Reset, start, mem[0]=ADD r0, dec_ready=1 -> dec_valid 2 cycles after start, dec_opcode=0000, dec_pc=0.
REQ-037 mem[1]=LOAD r1 op=5, dec_ready low 4 cycles -> fields/dec_pc=1 stable 4 cycles, accepted on 5th, next fetch at 2.
REQ-038 mem[0]=NOP, mem[1]=NOP, mem[2]=STORE r2 -> first issue dec_pc=2, dec_opcode=0111, dec_reg=2.
REQ-039 mem[31]=XOR accepted -> halted=1, busy=0, no further dec_valid; start -> refetch from address 0.
REQ-040 mem[3]=4'b1010 word: with FETCH_ILLEGAL_TRAP_EN -> illegal=1, halted=1, pc=3; without -> skipped, next issue dec_pc=4.
REQ-041 rst_n low while dec_valid=1 at pc=7 -> dec_valid=0 same cycle; after release, IDLE until start, restart at pc=0.
